// File: rtl/conv3_dw_window_if.sv
// Pixel-in / window-out bundle for conv3_dw_window.
// Signals: valid, input_act (in); output_win, ready, frame_done (out).
interface conv3_dw_window_if #(
    parameter int CH = 16,
    parameter int DW = 8
);
    logic                   valid;
    logic [CH*DW-1:0]       input_act;
    logic [9*CH*DW-1:0]     output_win;
    logic                   ready;
    logic                   frame_done;

    modport master (
        output valid, input_act,
        input  output_win, ready, frame_done
    );

    modport slave (
        input  valid, input_act,
        output output_win, ready, frame_done
    );
endinterface

// File: rtl/conv3_dw_window.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 shift array.
// Ports: clk, rstn (async, active-low), io (slave: valid/input_act in,
// output_win/ready/frame_done out). Optional CONV3_DW_WINDOW_STRIDE2_EN
// flags only stride-2 window positions.
module conv3_dw_window #(
    parameter int CH    = 16,
    parameter int DW    = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic              clk,
    input  logic              rstn,
    conv3_dw_window_if.slave  io
);
    localparam int PW = CH * DW;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PW-1:0]    lb0 [IMG_W];
    logic [PW-1:0]    lb1 [IMG_W];
    logic [PW-1:0]    win [9];
    logic [PW-1:0]    win_nxt [9];
    logic [9*PW-1:0]  win_flat;
    logic [9*PW-1:0]  out_q;
    logic             ready_q;
    logic             done_q;
    logic             last_col;
    logic             last_row;
    logic             hit;

    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));

`ifdef CONV3_DW_WINDOW_STRIDE2_EN
    // (row-2) even <=> row even, same for col
    assign hit = io.valid && (row >= RW'(2)) && (col >= CW'(2))
                 && !row[0] && !col[0];
`else
    assign hit = io.valid && (row >= RW'(2)) && (col >= CW'(2));
`endif

    // Line buffers read-before-write; not reset on purpose
    always_ff @(posedge clk) begin
        if (io.valid) begin
            lb1[col] <= lb0[col];
            lb0[col] <= io.input_act;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_nxt[3*i]   = win[3*i+1];
            win_nxt[3*i+1] = win[3*i+2];
            win_nxt[3*i+2] = win[3*i+2];
        end
        win_nxt[2] = lb1[col];
        win_nxt[5] = lb0[col];
        win_nxt[8] = io.input_act;
    end

    always_comb begin
        win_flat = '0;
        for (int k = 0; k < 9; k++)
            win_flat[k*PW +: PW] = win_nxt[k];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col     <= '0;
            row     <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            for (int k = 0; k < 9; k++)
                win[k] <= '0;
        end else begin
            ready_q <= hit;
            done_q  <= io.valid && last_col && last_row;
            if (io.valid) begin
                for (int k = 0; k < 9; k++)
                    win[k] <= win_nxt[k];
                col <= last_col ? '0 : col + CW'(1);
                if (last_col)
                    row <= last_row ? '0 : row + RW'(1);
            end
            // Output holds its last flagged window between pulses
            if (hit)
                out_q <= win_flat;
        end
    end

    assign io.ready      = ready_q;
    assign io.frame_done = done_q;
    assign io.output_win = out_q;
endmodule

// File: tb/tb_conv3_dw_window.sv
// Self-checking bench for conv3_dw_window (4x4, 5x3, 16x16, 6x6 instances).
// Scoreboard of expected windows built from a stored image of each frame.
module tb_conv3_dw_window;
    localparam int CH = 16;
    localparam int DW = 8;
    localparam int PW = CH * DW;
    localparam int WW = 9 * PW;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          valid;
    logic [PW-1:0] act;
    int            sel;

    conv3_dw_window_if #(.CH(CH), .DW(DW)) if0 ();
    conv3_dw_window_if #(.CH(CH), .DW(DW)) if1 ();
    conv3_dw_window_if #(.CH(CH), .DW(DW)) if2 ();
    conv3_dw_window_if #(.CH(CH), .DW(DW)) if3 ();

    assign if0.valid = (sel == 0) ? valid : 1'b0;
    assign if1.valid = (sel == 1) ? valid : 1'b0;
    assign if2.valid = (sel == 2) ? valid : 1'b0;
    assign if3.valid = (sel == 3) ? valid : 1'b0;
    assign if0.input_act = act;
    assign if1.input_act = act;
    assign if2.input_act = act;
    assign if3.input_act = act;

    conv3_dw_window #(.CH(CH), .DW(DW), .IMG_W(4), .IMG_H(4))
        u0 (.clk(clk), .rstn(rstn), .io(if0));
    conv3_dw_window #(.CH(CH), .DW(DW), .IMG_W(5), .IMG_H(3))
        u1 (.clk(clk), .rstn(rstn), .io(if1));
    conv3_dw_window #(.CH(CH), .DW(DW), .IMG_W(16), .IMG_H(16))
        u2 (.clk(clk), .rstn(rstn), .io(if2));
    conv3_dw_window #(.CH(CH), .DW(DW), .IMG_W(6), .IMG_H(6))
        u3 (.clk(clk), .rstn(rstn), .io(if3));

    logic          ready;
    logic          fd;
    logic [WW-1:0] win;

    always_comb begin
        ready = if0.ready;
        fd    = if0.frame_done;
        win   = if0.output_win;
        case (sel)
            1: begin ready = if1.ready; fd = if1.frame_done; win = if1.output_win; end
            2: begin ready = if2.ready; fd = if2.frame_done; win = if2.output_win; end
            3: begin ready = if3.ready; fd = if3.frame_done; win = if3.output_win; end
            default: ;
        endcase
    end

    int W_of [4] = '{4, 5, 16, 6};
    int H_of [4] = '{4, 3, 16, 6};

    logic [PW-1:0] img [16][16];
    int            rc [4];
    int            cc [4];
    logic [WW-1:0] last_win [4];
    logic [WW-1:0] sbq [$];
    int            errors = 0;
    int            checks = 0;
    int            pulses = 0;

    function automatic bit flag(int r, int c);
        if (r < 2 || c < 2) return 1'b0;
`ifdef CONV3_DW_WINDOW_STRIDE2_EN
        return ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int expcount(int w, int h);
`ifdef CONV3_DW_WINDOW_STRIDE2_EN
        return ((h - 1) / 2) * ((w - 1) / 2);
`else
        return (h - 2) * (w - 2);
`endif
    endfunction

    function automatic logic [PW-1:0] pixv(int r, int c);
        logic [7:0] b;
        b = 8'(16 * r + c);
        return {CH{b}};
    endfunction

    function automatic logic [WW-1:0] build(int r, int c);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*PW +: PW] = img[r-2+i][c-2+j];
        return w;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic chk_win(input string n, input logic [WW-1:0] a, input logic [WW-1:0] e);
        int bad;
        checks++;
        bad = -1;
        for (int k = 8; k >= 0; k--)
            if (a[k*PW +: PW] !== e[k*PW +: PW]) bad = k;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s tap%0d: got %h want %h (t=%0t)", n, bad,
                     a[bad*PW +: PW], e[bad*PW +: PW], $time);
        end
    endtask

    task automatic step(input bit v, input logic [PW-1:0] p);
        int r, c, w, h;
        bit f, last;
        logic [WW-1:0] e;
        r = rc[sel];
        c = cc[sel];
        w = W_of[sel];
        h = H_of[sel];
        f = 1'b0;
        last = 1'b0;
        @(negedge clk);
        valid = v;
        act = p;
        if (v) begin
            img[r][c] = p;
            f = flag(r, c);
            last = (r == h - 1) && (c == w - 1);
            if (f) sbq.push_back(build(r, c));
            if (c == w - 1) begin
                cc[sel] = 0;
                rc[sel] = (r == h - 1) ? 0 : r + 1;
            end else begin
                cc[sel] = c + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("ready", 64'(ready), 64'(f));
        chk("frame_done", 64'(fd), 64'(last));
        if (f) begin
            pulses++;
            e = sbq.pop_front();
            chk_win("win", win, e);
            last_win[sel] = e;
        end else begin
            chk_win("hold", win, last_win[sel]);
        end
    endtask

    task automatic do_reset();
        valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_fd", 64'(fd), 64'd0);
        for (int k = 0; k < 4; k++) begin
            rc[k] = 0;
            cc[k] = 0;
            last_win[k] = '0;
        end
        sbq.delete();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    typedef struct {
        int         r;
        int         c;
        bit         rdy;
        bit         fdn;
        logic [7:0] t0;
        logic [7:0] t4;
        logic [7:0] t8;
    } vec_t;

    vec_t tbl [16];
    logic [PW-1:0] rp;
    int n, cyc;
    bit v;

    initial begin
        valid = 1'b0;
        act = '0;
        sel = 0;
        for (int k = 0; k < 4; k++) begin
            rc[k] = 0;
            cc[k] = 0;
            last_win[k] = '0;
        end

        for (int i = 0; i < 16; i++)
            tbl[i] = '{i / 4, i % 4, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0};
        tbl[10].rdy = 1'b1; tbl[10].t0 = 8'h00; tbl[10].t4 = 8'h11; tbl[10].t8 = 8'h22;
`ifndef CONV3_DW_WINDOW_STRIDE2_EN
        tbl[11].rdy = 1'b1; tbl[11].t0 = 8'h01; tbl[11].t4 = 8'h12; tbl[11].t8 = 8'h23;
        tbl[14].rdy = 1'b1; tbl[14].t0 = 8'h10; tbl[14].t4 = 8'h21; tbl[14].t8 = 8'h32;
        tbl[15].rdy = 1'b1; tbl[15].t0 = 8'h11; tbl[15].t4 = 8'h22; tbl[15].t8 = 8'h33;
`endif
        tbl[15].fdn = 1'b1;

        // Reset state of every instance
        #12;
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            chk("init_ready", 64'(ready), 64'd0);
            chk("init_fd", 64'(fd), 64'd0);
            chk_win("init_win", win, '0);
        end
        sel = 0;
        @(negedge clk);
        rstn = 1'b1;

        // Basic 4x4, table-driven
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, pixv(tbl[i].r, tbl[i].c));
            chk("tbl_ready", 64'(ready), 64'(tbl[i].rdy));
            chk("tbl_fd", 64'(fd), 64'(tbl[i].fdn));
            if (tbl[i].rdy) begin
                chk("tbl_t0", 64'(win[0 +: 8]), 64'(tbl[i].t0));
                chk("tbl_t4", 64'(win[4*PW +: 8]), 64'(tbl[i].t4));
                chk("tbl_t8", 64'(win[8*PW +: 8]), 64'(tbl[i].t8));
            end
        end
        step(1'b0, '0);
        chk("basic_pulses", 64'(pulses), 64'(expcount(4, 4)));

        // 4x4 with ~30% valid duty
        pulses = 0;
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 2000) begin
            v = ($urandom_range(0, 99) < 30);
            step(v, v ? pixv(n / 4, n % 4) : '0);
            if (v) n++;
            cyc++;
        end
        step(1'b0, '0);
        chk("gap_done", 64'(n), 64'd16);
        chk("gap_pulses", 64'(pulses), 64'(expcount(4, 4)));

        // 5x3 back-to-back frames
        sel = 1;
        pulses = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 15; i++)
                step(1'b1, pixv(i / 5, i % 5));
        step(1'b0, '0);
        chk("b2b_pulses", 64'(pulses), 64'(2 * expcount(5, 3)));

        // Reset mid-frame on 4x4
        sel = 0;
        for (int i = 0; i < 10; i++)
            step(1'b1, pixv(i / 4, i % 4));
        do_reset();
        for (int i = 0; i < 11; i++)
            step(1'b1, pixv(i / 4, i % 4));
        chk("pre_rst_ready", 64'(ready), 64'd1);
        do_reset();
        pulses = 0;
        for (int i = 0; i < 16; i++)
            step(1'b1, pixv(i / 4, i % 4));
        step(1'b0, '0);
        chk("rst_pulses", 64'(pulses), 64'(expcount(4, 4)));

        // 16x16 random data
        sel = 2;
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < CH; k++)
                rp[k*DW +: DW] = 8'($urandom_range(0, 255));
            step(1'b1, rp);
        end
        step(1'b0, '0);
        chk("full_pulses", 64'(pulses), 64'(expcount(16, 16)));

        // 6x6 pattern (stride-2 positions when enabled)
        sel = 3;
        pulses = 0;
        for (int i = 0; i < 36; i++)
            step(1'b1, pixv(i / 6, i % 6));
        step(1'b0, '0);
        chk("six_pulses", 64'(pulses), 64'(expcount(6, 6)));

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv3_dw_window.md
Name: conv3_dw_window

Overview:
- Sliding-window generator between the pointwise conv stage (16 ch × 8 b pixel stream) and the following 3×3 depthwise conv.
- Buffers two image rows and emits one complete 3×3 × CH window per valid output position.
- Output position is "valid" in the convolution sense: no padding, stride 1, raster order.
- Streaming only, no backpressure; the downstream depthwise MAC consumes windows combinationally.

Parameters:
- CH, 16, channels per pixel.
- DW, 8, bits per channel.
- IMG_W, 16, frame width in pixels (≥3).
- IMG_H, 16, frame height in pixels (≥3).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- valid  input  1  input_act carries one pixel this cycle
- input_act  input  CH*DW  pixel; channel n at [n*DW +: DW]
- output_win  output  9*CH*DW  window; tap k=3*i+j (i row 0=top, j col 0=left) at [k*CH*DW +: CH*DW]; channel packing within a tap is the same as input_act
- ready  output  1  output_win valid this cycle (single-cycle pulse per window)
- frame_done  output  1  pulse with the last pixel's response of each frame

Behaviour:
- Reset values: ready=0, frame_done=0, output_win=0, col=0, row=0, window shift registers=0. Line-buffer RAM is not reset; its contents are don't-care until overwritten.
- Counters:
  - col (0..IMG_W-1) and row (0..IMG_H-1) advance only on valid.
  - col wraps to 0 after IMG_W-1 and increments row.
  - row wraps to 0 after IMG_H-1 (end of frame).
  - No valid means no state change.
- Line buffers: two buffers of IMG_W × CH*DW.
  - On valid at col c: lb1[c] ← lb0[c] and lb0[c] ← input_act.
  - The column read returns pre-write values (read-before-write).
- Window registers: a 3×3 shift array.
  - On valid, every row shifts left one column.
  - New right column is: tap 2 = old lb1[c], tap 5 = old lb0[c], tap 8 = input_act.
- Output condition: on valid with row≥2 and col≥2, next cycle ready=1 and output_win holds the window whose top-left pixel is (row-2, col-2).
  - Latency is exactly 1 cycle from accepted pixel to ready.
  - ready=0 on all other cycles.
  - output_win holds its last value when ready=0.
- Row-boundary columns: window columns straddling a row boundary (col<2) are shifted in but never flagged.
- Window count: exactly (IMG_H-2)*(IMG_W-2) pulses per frame.
- frame_done: asserted the cycle after the valid with row=IMG_H-1 and col=IMG_W-1, coincident with the last ready.
- Back-to-back frames: pixel (0,0) of the next frame may arrive on the cycle immediately after the last pixel. No bubble is required and no cross-frame window is ever flagged.
- Gaps: valid may deassert for any number of cycles anywhere in a frame; outputs are identical to the gapless case apart from timing.
- Reset mid-frame: counters return to (0,0) and ready/frame_done drop immediately (async). The first valid after release is pixel (0,0) of a fresh frame.
- Width rule: pure data movement; no arithmetic on pixel data and no sign interpretation.

Optional Feature:
- Macro: CONV3_DW_WINDOW_STRIDE2_EN.
- Defined:
  - ready is flagged only when (row-2) and (col-2) are both even, i.e. stride-2 output.
  - Count per frame is ceil((IMG_H-2)/2)*ceil((IMG_W-2)/2).
  - frame_done still pulses after the last pixel, even if no window is flagged on that cycle.
- Undefined: stride 1 as above.
- Counters and buffers are identical in both builds.

Test Plan:
- Stimulus convention: channel n of pixel (r,c) = 16*r+c for all n.
- Basic (IMG_W=IMG_H=4): feed 16 gapless pixels.
  - Exactly 4 ready pulses, the first one cycle after pixel (2,2).
  - First window: tap0=0x00, tap4=0x11, tap8=0x22.
  - Last window: tap0=0x11, tap8=0x33.
  - frame_done coincides with the 4th pulse.
- Gaps (4×4): random valid duty of 30%.
  - Same 4 windows in the same order.
  - Each ready exactly 1 cycle after pixels (2,2), (2,3), (3,2), (3,3).
- Back-to-back (IMG_W=5, IMG_H=3): two frames with no bubble.
  - 3 pulses per frame.
  - Frame 2 first window tap0=0x00, tap8=0x22.
  - No pulse while frame 2 rows 0–1 are loading.
- Reset mid-frame (4×4): assert rstn=0 after pixel (2,1).
  - ready=0 and frame_done=0 immediately.
  - A subsequent full frame yields the 4 correct windows.
- Default size (16×16) with random data: 196 pulses and every window matches the reference model.
- CONV3_DW_WINDOW_STRIDE2_EN (IMG_W=IMG_H=6):
  - 4 pulses, with top-left pixels (0,0), (0,2), (2,0), (2,2).
  - Tap0 values 0x00, 0x02, 0x20, 0x22.
